// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered ALU between N_REQ requesters, tags each op, routes results back.
// Latency: operands reach alu_* one edge after grant; result strobes ALU_LAT+2 edges after grant.
// Backpressure: none downstream; req_ready is a pure function of req_valid and the RR pointer.
// Option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no pointer).
module alu_arbiter #(
   parameter int N_REQ       = 2,
   parameter int INSTR_WIDTH = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int ALU_LAT     = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [N_REQ-1:0]             req_valid,
   output logic [N_REQ-1:0]             req_ready,
   input  logic [N_REQ*DATA_WIDTH-1:0]  req_rs1,
   input  logic [N_REQ*DATA_WIDTH-1:0]  req_rs2,
   input  logic [N_REQ*INSTR_WIDTH-1:0] req_op,
   output logic [N_REQ-1:0]             rsp_valid,
   output logic [DATA_WIDTH-1:0]        rsp_data,
   output logic [DATA_WIDTH-1:0]        alu_rs1,
   output logic [DATA_WIDTH-1:0]        alu_rs2,
   output logic [INSTR_WIDTH-1:0]       alu_operation,
   input  logic [DATA_WIDTH-1:0]        alu_rd,
   output logic                         busy
);

   localparam int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int DEPTH = ALU_LAT + 1;

   logic                         w_gnt_any;
   logic [PW-1:0]                w_gnt_idx;
   logic                         w_xfer;
   logic [N_REQ-1:0]             w_grant;
   logic [DATA_WIDTH-1:0]        w_rs1;
   logic [DATA_WIDTH-1:0]        w_rs2;
   logic [INSTR_WIDTH-1:0]       w_op;

   logic [DATA_WIDTH-1:0]        r_alu_rs1;
   logic [DATA_WIDTH-1:0]        r_alu_rs2;
   logic [INSTR_WIDTH-1:0]       r_alu_op;
   logic [DEPTH-1:0]             r_tag_vld;
   logic [DEPTH-1:0][PW-1:0]     r_tag_idx;
   logic [N_REQ-1:0]             r_rsp_vld;
   logic [DATA_WIDTH-1:0]        r_rsp_data;

`ifndef ALU_ARB_FIXED_PRIO_EN
   logic [PW-1:0]                r_ptr;
   int                           w_j;
`endif

   // Pick the winner: fixed priority from index 0, or round-robin starting at r_ptr.
   always_comb begin
      w_gnt_any = 1'b0;
      w_gnt_idx = '0;
`ifdef ALU_ARB_FIXED_PRIO_EN
      // Descending scan so the lowest requesting index is the last (winning) assignment.
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = PW'(i);
         end
      end
`else
      w_j = 0;
      // Descending scan of offsets so the candidate nearest to r_ptr wins.
      for (int k = N_REQ - 1; k >= 0; k--) begin
         w_j = int'(r_ptr) + k;
         if (w_j >= N_REQ) w_j = w_j - N_REQ;
         if (req_valid[w_j]) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = PW'(w_j);
         end
      end
`endif
   end

   // Reset blocks the grant so nothing is accepted while rst_n is low.
   assign w_xfer = w_gnt_any & rst_n;

   // One-hot grant and operand mux for the winning requester.
   always_comb begin
      w_grant = '0;
      w_rs1   = '0;
      w_rs2   = '0;
      w_op    = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_xfer && (w_gnt_idx == PW'(i))) begin
            w_grant[i] = 1'b1;
            w_rs1      = req_rs1[i*DATA_WIDTH +: DATA_WIDTH];
            w_rs2      = req_rs2[i*DATA_WIDTH +: DATA_WIDTH];
            w_op       = req_op[i*INSTR_WIDTH +: INSTR_WIDTH];
         end
      end
   end

`ifndef ALU_ARB_FIXED_PRIO_EN
   // Pointer moves one past the last winner, wrapping at N_REQ-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (w_xfer) begin
         r_ptr <= (w_gnt_idx == PW'(N_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
      end
   end
`endif

   // Issue register: ALU inputs hold their last values when nothing is granted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_alu_rs1 <= '0;
         r_alu_rs2 <= '0;
         r_alu_op  <= '0;
      end else if (w_xfer) begin
         r_alu_rs1 <= w_rs1;
         r_alu_rs2 <= w_rs2;
         r_alu_op  <= w_op;
      end
   end

   // Owner tag travels alongside the op; its tail lines up with alu_rd.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tag_vld <= '0;
         r_tag_idx <= '0;
      end else begin
         r_tag_vld <= {r_tag_vld[DEPTH-2:0], w_xfer};
         r_tag_idx <= {r_tag_idx[DEPTH-2:0], w_gnt_idx};
      end
   end

   // Result register: one-hot strobe to the owner; data holds between results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_vld  <= '0;
         r_rsp_data <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            r_rsp_vld[i] <= r_tag_vld[DEPTH-1] && (r_tag_idx[DEPTH-1] == PW'(i));
         end
         if (r_tag_vld[DEPTH-1]) r_rsp_data <= alu_rd;
      end
   end

   assign req_ready     = w_grant;
   assign alu_rs1       = r_alu_rs1;
   assign alu_rs2       = r_alu_rs2;
   assign alu_operation = r_alu_op;
   assign rsp_valid     = r_rsp_vld;
   assign rsp_data      = r_rsp_data;
   assign busy          = (|r_tag_vld) | (|r_rsp_vld);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed table, corner sequences, and random traffic vs a queue model.
// The ALU stand-in computes a registered result one cycle after its inputs.
module tb_alu_arbiter;

   localparam int DW = 32;
   localparam int IW = 4;
   localparam int NR = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n;
   logic [1:0]        req_valid, req_ready, rsp_valid;
   logic [2*DW-1:0]   req_rs1, req_rs2;
   logic [2*IW-1:0]   req_op;
   logic [DW-1:0]     rsp_data, alu_rs1, alu_rs2;
   logic [DW-1:0]     alu_rd = '0;
   logic [IW-1:0]     alu_op;
   logic              busy;

   logic [2:0]        req_valid3;
   logic [2:0]        req_ready3, rsp_valid3;
   logic [3*DW-1:0]   req_rs1_3 = '0;
   logic [3*DW-1:0]   req_rs2_3 = '0;
   logic [3*IW-1:0]   req_op3 = '0;
   logic [DW-1:0]     rsp_data3, alu_rs1_3, alu_rs2_3;
   logic [DW-1:0]     alu_rd3 = '0;
   logic [IW-1:0]     alu_op3;
   logic              busy3;

   alu_arbiter #(.N_REQ(2), .INSTR_WIDTH(IW), .DATA_WIDTH(DW), .ALU_LAT(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_rs1(req_rs1), .req_rs2(req_rs2), .req_op(req_op),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_operation(alu_op),
      .alu_rd(alu_rd), .busy(busy));

   alu_arbiter #(.N_REQ(3), .INSTR_WIDTH(IW), .DATA_WIDTH(DW), .ALU_LAT(1)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
      .req_rs1(req_rs1_3), .req_rs2(req_rs2_3), .req_op(req_op3),
      .rsp_valid(rsp_valid3), .rsp_data(rsp_data3),
      .alu_rs1(alu_rs1_3), .alu_rs2(alu_rs2_3), .alu_operation(alu_op3),
      .alu_rd(alu_rd3), .busy(busy3));

   function automatic logic [31:0] alufn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         default: return a;
      endcase
   endfunction

   // Stand-in for alu_i: result registered one cycle after its inputs.
   always @(posedge clk) alu_rd <= alufn(alu_rs1, alu_rs2, alu_op);

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
      end
   endtask

   // Reference model: pending results with their due cycle, in issue order.
   typedef struct { int due; int who; logic [31:0] dat; } resp_t;
   resp_t       m_q[$];
   int          m_ptr = 0;
   int          cyc = 0;
   logic [1:0]  m_rvld = '0;
   logic [31:0] m_rdat = '0;
   logic [31:0] m_a1 = '0, m_a2 = '0;
   logic [3:0]  m_op = '0;

   logic [1:0]  obs_ready, obs_rvld;
   logic [31:0] obs_rdat, obs_alu1;
   logic        obs_busy;
   logic [2:0]  obs_ready3;
   logic [2:0]  t3_v = '0;

   function automatic int pick(input logic [1:0] v, input int p);
`ifdef ALU_ARB_FIXED_PRIO_EN
      for (int k = 0; k < NR; k++) if (v[k]) return k;
`else
      for (int k = 0; k < NR; k++) if (v[(p + k) % NR]) return (p + k) % NR;
`endif
      return -1;
   endfunction

   // One clock: drive at posedge+1, check at the falling edge, advance the model.
   task automatic cycle(input logic [1:0] v, input logic [63:0] a, input logic [63:0] b,
                        input logic [7:0] op, input logic rst);
      int         g;
      logic [1:0] exp_rdy;
      logic       exp_busy;
      rst_n = rst; req_valid = v; req_rs1 = a; req_rs2 = b; req_op = op;
      req_valid3 = t3_v;
      #4;
      g = -1;
      if (!rst) begin
         m_q.delete(); m_ptr = 0; m_rvld = '0; m_rdat = '0;
         m_a1 = '0; m_a2 = '0; m_op = '0; exp_busy = 1'b0;
      end else begin
         m_rvld = '0;
         if (m_q.size() > 0 && m_q[0].due == cyc) begin
            m_rvld[m_q[0].who] = 1'b1;
            m_rdat = m_q[0].dat;
            void'(m_q.pop_front());
         end
         exp_busy = (m_rvld != 2'b00) || (m_q.size() > 0);
         g = pick(v, m_ptr);
      end
      exp_rdy = (g >= 0) ? 2'(1 << g) : 2'b00;
      chk("req_ready", {30'd0, req_ready}, {30'd0, exp_rdy});
      chk("rsp_valid", {30'd0, rsp_valid}, {30'd0, m_rvld});
      chk("rsp_data", rsp_data, m_rdat);
      chk("busy", {31'd0, busy}, {31'd0, exp_busy});
      chk("alu_rs1", alu_rs1, m_a1);
      chk("alu_rs2", alu_rs2, m_a2);
      chk("alu_op", {28'd0, alu_op}, {28'd0, m_op});
      obs_ready = req_ready; obs_rvld = rsp_valid; obs_rdat = rsp_data;
      obs_busy = busy; obs_alu1 = alu_rs1; obs_ready3 = req_ready3;
      if (g >= 0) begin
         m_a1 = a[g*DW +: DW]; m_a2 = b[g*DW +: DW]; m_op = op[g*IW +: IW];
         m_q.push_back('{due: cyc + 3, who: g, dat: alufn(m_a1, m_a2, m_op)});
         m_ptr = (g + 1) % NR;
      end
      @(posedge clk); #1;
      cyc++;
   endtask

   typedef struct {
      logic [1:0]  v;
      logic [31:0] a0, b0, a1, b1;
      logic [1:0]  rdy, rvld;
      logic [31:0] rdat;
      logic        bsy;
      logic [31:0] alu1;
   } vec_t;
   vec_t tbl[15];

   initial begin
      int hits;
      logic [1:0] prev;
      // Single ADD 5+7 from req0, then alternating grants with both requesting (all ADD).
      tbl[0]  = '{2'b01,   5,   7,   0,   0, 2'b01, 2'b00,   0, 1'b0,   0};
      tbl[1]  = '{2'b00,   0,   0,   0,   0, 2'b00, 2'b00,   0, 1'b1,   5};
      tbl[2]  = '{2'b00,   0,   0,   0,   0, 2'b00, 2'b00,   0, 1'b1,   5};
      tbl[3]  = '{2'b00,   0,   0,   0,   0, 2'b00, 2'b01,  12, 1'b1,   5};
      tbl[4]  = '{2'b10,   0,   0, 100,   1, 2'b10, 2'b00,  12, 1'b0,   5};
      tbl[5]  = '{2'b11,   1,   2,   3,   4, 2'b01, 2'b00,  12, 1'b1, 100};
      tbl[6]  = '{2'b11,  10,  20,  30,  40, 2'b10, 2'b00,  12, 1'b1,   1};
      tbl[7]  = '{2'b11,   5,   5,   6,   6, 2'b01, 2'b10, 101, 1'b1,  30};
      tbl[8]  = '{2'b11,   1,   1,   2,   2, 2'b10, 2'b01,   3, 1'b1,   5};
      tbl[9]  = '{2'b11,   7,   8,   9,   9, 2'b01, 2'b10,  70, 1'b1,   2};
      tbl[10] = '{2'b11, 100, 200, 300, 400, 2'b10, 2'b01,  10, 1'b1,   7};
      tbl[11] = '{2'b00,   0,   0,   0,   0, 2'b00, 2'b10,   4, 1'b1, 300};
      tbl[12] = '{2'b00,   0,   0,   0,   0, 2'b00, 2'b01,  15, 1'b1, 300};
      tbl[13] = '{2'b00,   0,   0,   0,   0, 2'b00, 2'b10, 700, 1'b1, 300};
      tbl[14] = '{2'b00,   0,   0,   0,   0, 2'b00, 2'b00, 700, 1'b0, 300};

      rst_n = 1'b0; req_valid = '0; req_rs1 = '0; req_rs2 = '0; req_op = '0;
      req_valid3 = '0;
      @(posedge clk); #1;

      // Reset state, with requests present that must not be granted.
      cycle(2'b11, '0, '0, '0, 1'b0);
      chk("reset_ready", {30'd0, obs_ready}, 32'd0);
      cycle(2'b00, '0, '0, '0, 1'b0);

      // Three-requester wrap: req2 then req0, then the pointer sits at 1.
      t3_v = 3'b100; cycle(2'b00, '0, '0, '0, 1'b1);
      chk("n3_first", {29'd0, obs_ready3}, 32'd4);
      t3_v = 3'b001; cycle(2'b00, '0, '0, '0, 1'b1);
      chk("n3_wrap", {29'd0, obs_ready3}, 32'd1);
      t3_v = 3'b111; cycle(2'b00, '0, '0, '0, 1'b1);
`ifdef ALU_ARB_FIXED_PRIO_EN
      chk("n3_after", {29'd0, obs_ready3}, 32'd1);
`else
      chk("n3_after", {29'd0, obs_ready3}, 32'd2);
`endif
      t3_v = 3'b000;

`ifdef ALU_ARB_FIXED_PRIO_EN
      // Fixed priority: req0 always wins while it requests.
      for (int k = 0; k < 4; k++) begin
         cycle(2'b11, {32'd0, 32'(k)}, {32'd1, 32'd1}, 8'h00, 1'b1);
         chk("fixed_ready", {30'd0, obs_ready}, 32'd1);
      end
      cycle(2'b10, {32'd9, 32'd0}, {32'd1, 32'd0}, 8'h00, 1'b1);
      chk("fixed_req1", {30'd0, obs_ready}, 32'd2);
      for (int k = 0; k < 4; k++) cycle(2'b00, '0, '0, '0, 1'b1);
`else
      for (int i = 0; i < 15; i++) begin
         cycle(tbl[i].v, {tbl[i].a1, tbl[i].a0}, {tbl[i].b1, tbl[i].b0}, 8'h00, 1'b1);
         chk($sformatf("tbl%0d_ready", i), {30'd0, obs_ready}, {30'd0, tbl[i].rdy});
         chk($sformatf("tbl%0d_rvld", i), {30'd0, obs_rvld}, {30'd0, tbl[i].rvld});
         chk($sformatf("tbl%0d_rdat", i), obs_rdat, tbl[i].rdat);
         chk($sformatf("tbl%0d_busy", i), {31'd0, obs_busy}, {31'd0, tbl[i].bsy});
         chk($sformatf("tbl%0d_alu1", i), obs_alu1, tbl[i].alu1);
      end
`endif

      // Reset while req1 ops are in flight: they are dropped, req0 wins first afterwards.
      cycle(2'b10, {32'd11, 32'd0}, {32'd22, 32'd0}, 8'h00, 1'b1);
      cycle(2'b10, {32'd33, 32'd0}, {32'd44, 32'd0}, 8'h00, 1'b1);
      cycle(2'b00, '0, '0, '0, 1'b0);
      cycle(2'b11, {32'd2, 32'd3}, {32'd4, 32'd5}, 8'h00, 1'b1);
      chk("post_reset_grant", {30'd0, obs_ready}, 32'd1);
      hits = 0;
      for (int k = 0; k < 6; k++) begin
         cycle(2'b00, '0, '0, '0, 1'b1);
         if (obs_rvld != 2'b00) hits++;
      end
      chk("reset_drop_count", 32'(hits), 32'd1);

      // Eight back-to-back ops from req0.
      hits = 0;
      prev = 2'b00;
      for (int k = 0; k < 8; k++) begin
         cycle(2'b01, {$urandom, $urandom}, {$urandom, $urandom}, 8'h21, 1'b1);
         chk("stream_ready", {30'd0, obs_ready}, 32'd1);
         if (obs_rvld[0]) hits++;
         prev = obs_rvld;
      end
      for (int k = 0; k < 6; k++) begin
         cycle(2'b00, '0, '0, '0, 1'b1);
         if (obs_rvld[0]) hits++;
         if (prev[0] && !obs_rvld[0]) chk("stream_busy_drop", {31'd0, obs_busy}, 32'd0);
         prev = obs_rvld;
      end
      chk("stream_rsp_count", 32'(hits), 32'd8);

      // Random traffic with occasional resets.
      for (int k = 0; k < 400; k++) begin
         cycle(2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom},
               {4'($urandom_range(0, 5)), 4'($urandom_range(0, 5))},
               ($urandom_range(0, 63) != 0));
      end
      for (int k = 0; k < 5; k++) cycle(2'b00, '0, '0, '0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
